usart_rx_frame: RTL and testbench
=================================

// Module: usart_rx_frame
// PURPOSE
// Receive-side frame engine of the USART. Sits directly downstream of the RXD synchroniser/voter.
// It consumes the voted bit (dout), the falling-edge flag (fe_det) and the oversample strobe (en) that drives the voter.
// It detects the start bit, samples data/parity/stop at bit centres, and deserialises 5..9-bit characters LSB first.
// It holds one character in a receive buffer with FE/PE/DOR flags for the register file.
// PARAMETERS
// P_START_CHK  1     1: re-check start bit at its centre, abort if high (false start); 0: no check
// P_FLUSH_DIS  1     1: rx_en low clears buffer and flags; 0: buffer kept when receiver disabled
// PORTS
// clk        in   1  system clock
// rst        in   1  synchronous reset, active high
// samp_tick  in   1  oversample strobe, 1-clk pulse (same signal as voter en)
// rxd_v      in   1  voted RXD level from synchroniser/voter
// fe_det     in   1  falling-edge detect from voter (valid on samp_tick cycles)
// rx_en      in   1  receiver enable (RXEN)
// u2x        in   1  0: 16 ticks/bit, 1: 8 ticks/bit
// chr_size   in   3  UCSZ: 0..3 = 5..8 bits, 7 = 9 bits, 4..6 treated as 8
// upm        in   2  parity: 2'b10 even, 2'b11 odd, else none
// rx_rd      in   1  1-clk pulse: UDR read, pops buffer
// rx_data    out  9  buffered character, right-justified, unused MSBs 0
// rxc        out  1  buffer full (RXC flag)
// fe         out  1  frame error of buffered char (stop bit sampled 0)
// pe         out  1  parity error of buffered char
// dor        out  1  data overrun: a char completed while buffer full
// busy       out  1  frame in progress (state != IDLE)
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state IDLE, counters 0, rx_data=0, rxc=fe=pe=dor=busy=0.
// - OS = u2x ? 8 : 16. HALF = OS/2. os_cnt is 4 bits; it advances only on samp_tick cycles.
// - IDLE: when rx_en & samp_tick & fe_det -> START, os_cnt=0, bit_cnt=0.
// - Any non-IDLE state: on each samp_tick, os_cnt = (os_cnt==OS-1) ? 0 : os_cnt+1.
//   Sample point = the samp_tick cycle where the new os_cnt==HALF. Sampled value = rxd_v in that cycle.
// - START, at sample point: if P_START_CHK & rxd_v==1 -> IDLE (discard, no flags). Else -> DATA.
// - DATA: one bit per sample point into shreg[bit_cnt], bit_cnt++. Bit count N = 5,6,7,8,9 from chr_size.
//   After N bits -> PARITY if upm[1], else STOP.
// - PARITY, at sample point: pe_n = ^{data,rxd_v} ^ upm[0]. Nonzero = error. -> STOP.
// - STOP, at sample point: fe_n = ~rxd_v. Frame completes in this cycle and state -> IDLE in the same cycle.
//   A new start can then be detected from the next samp_tick. Only the first stop bit is checked.
// - Completion, same clk:
//   - If rxc==0 or rx_rd==1: load rx_data/fe/pe, rxc=1.
//   - If rxc==1 and rx_rd==0: new char lost, dor=1, buffer unchanged.
// - rx_rd with no completion: rxc=0, fe=pe=dor=0. rx_data holds its value.
// - rx_rd while rxc==0: no effect.
// - rx_en low: state -> IDLE next clk, frame in flight dropped.
//   If P_FLUSH_DIS, rx_data, rxc, fe, pe and dor are cleared.
// - chr_size/upm/u2x change mid-frame: undefined char content, FSM still returns to IDLE. No lockup.
// - rst mid-frame: full reset next clk, same as power-on reset.
// - Latency: rxc rises 1 clk after the stop-bit sample tick. Frame = (1+N+P+1) bits minus HALF ticks.
// TESTING
// - 16x, 8N1, send 0xA5 -> rxc=1 after stop sample, rx_data=0x0A5, fe=pe=dor=0.
// - u2x=1, 9-bit, even parity, send 0x1C3 with correct parity -> rx_data=0x1C3, pe=0.
//   Flip the parity bit -> pe=1.
// - 8N1 with stop bit forced 0 -> fe=1, rx_data holds the received byte.
// - Glitch: RXD low for 3 ticks, then high through the start centre -> no rxc, busy returns 0.
// - Two frames 0x11 then 0x22, no rx_rd -> rx_data=0x11, dor=1. Then rx_rd -> rxc=0, dor=0.
//   rx_rd in the completion cycle of the second frame -> rx_data=0x22, dor=0.
// - Drop rx_en mid-DATA, then rst mid-frame -> busy=0 and all outputs 0 next clk.
//   A following good frame 0x5A is received correctly.

Source files
------------

// File: rtl/usart_rx_frame.sv
// usart_rx_frame
// Receive-side frame engine of the USART. It takes the voted RXD level,
// the falling-edge flag and the oversample strobe from the synchroniser/voter.
// It finds the start bit and samples data, parity and stop at bit centres.
// Characters of 5..9 bits arrive LSB first. One received character is held
// in a buffer together with its FE/PE/DOR flags.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   samp_tick           oversample strobe (1-clk pulse)
//   rxd_v, fe_det       voted RXD level and falling-edge flag
//   rx_en               receiver enable
//   u2x                 0: 16 ticks/bit, 1: 8 ticks/bit
//   chr_size [2:0]      0..3 -> 5..8 bits, 7 -> 9 bits, 4..6 -> 8 bits
//   upm [1:0]           2'b10 even parity, 2'b11 odd parity, else none
//   rx_rd               buffer pop (UDR read)
//   rx_data [8:0]       buffered character, right-justified
//   rxc, fe, pe, dor    buffer full, frame error, parity error, data overrun
//   busy                a frame is in progress
module usart_rx_frame #(
  parameter bit P_START_CHK = 1'b1,
  parameter bit P_FLUSH_DIS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       samp_tick,
  input  logic       rxd_v,
  input  logic       fe_det,
  input  logic       rx_en,
  input  logic       u2x,
  input  logic [2:0] chr_size,
  input  logic [1:0] upm,
  input  logic       rx_rd,
  output logic [8:0] rx_data,
  output logic       rxc,
  output logic       fe,
  output logic       pe,
  output logic       dor,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] shreg_q, shreg_d;
  logic       pe_pend_q, pe_pend_d;
  logic [8:0] rx_data_q, rx_data_d;
  logic       rxc_q, rxc_d;
  logic       fe_q, fe_d;
  logic       pe_q, pe_d;
  logic       dor_q, dor_d;

  logic [3:0] os_max;
  logic [3:0] half;
  logic [3:0] os_nxt;
  logic [3:0] nbits;
  logic       samp;
  logic       done;

  always_comb begin
    os_max = u2x ? 4'd7 : 4'd15;
    half   = u2x ? 4'd4 : 4'd8;
    // >= instead of == keeps the counter bounded if u2x flips mid-frame
    os_nxt = (os_cnt_q >= os_max) ? 4'd0 : os_cnt_q + 4'd1;
    samp   = samp_tick && (state_q != S_IDLE) && (os_nxt == half);
    case (chr_size)
      3'd0:    nbits = 4'd5;
      3'd1:    nbits = 4'd6;
      3'd2:    nbits = 4'd7;
      3'd7:    nbits = 4'd9;
      default: nbits = 4'd8;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pe_pend_d = pe_pend_q;
    rx_data_d = rx_data_q;
    rxc_d     = rxc_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    dor_d     = dor_q;
    done      = 1'b0;

    if (samp_tick && (state_q != S_IDLE)) os_cnt_d = os_nxt;

    case (state_q)
      S_IDLE: begin
        if (samp_tick && fe_det) begin
          state_d   = S_START;
          os_cnt_d  = 4'd0;
          bit_cnt_d = 4'd0;
          shreg_d   = 9'd0;
          pe_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (samp) state_d = (P_START_CHK && rxd_v) ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (samp) begin
          shreg_d   = shreg_q | ({8'd0, rxd_v} << bit_cnt_q);
          bit_cnt_d = bit_cnt_q + 4'd1;
          // >= so a chr_size change mid-frame cannot trap the FSM here
          if (bit_cnt_q + 4'd1 >= nbits) state_d = upm[1] ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (samp) begin
          pe_pend_d = (^shreg_q) ^ rxd_v ^ upm[0];
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (samp) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the completion cycle makes room for the new character
    if (done) begin
      if (!rxc_q || rx_rd) begin
        rx_data_d = shreg_q;
        fe_d      = ~rxd_v;
        pe_d      = pe_pend_q;
        dor_d     = 1'b0;
        rxc_d     = 1'b1;
      end else begin
        dor_d = 1'b1;
      end
    end else if (rx_rd && rxc_q) begin
      rxc_d = 1'b0;
      fe_d  = 1'b0;
      pe_d  = 1'b0;
      dor_d = 1'b0;
    end

    if (!rx_en) begin
      state_d = S_IDLE;
      if (P_FLUSH_DIS) begin
        rx_data_d = 9'd0;
        rxc_d     = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        dor_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= 4'd0;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 9'd0;
      pe_pend_q <= 1'b0;
      rx_data_q <= 9'd0;
      rxc_q     <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      dor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      pe_pend_q <= pe_pend_d;
      rx_data_q <= rx_data_d;
      rxc_q     <= rxc_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      dor_q     <= dor_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rxc     = rxc_q;
  assign fe      = fe_q;
  assign pe      = pe_q;
  assign dor     = dor_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_rx_frame.sv
module tb_usart_rx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       samp_tick;
  logic       rxd_v;
  logic       fe_det;
  logic       rx_en;
  logic       u2x;
  logic [2:0] chr_size;
  logic [1:0] upm;
  logic       rx_rd;
  logic [8:0] rx_data;
  logic       rxc, fe, pe, dor, busy;

  int total = 0;
  int bad   = 0;
  logic prev_lvl = 1'b1;

  always #5 clk = ~clk;

  usart_rx_frame dut (
    .clk(clk), .rst(rst), .samp_tick(samp_tick), .rxd_v(rxd_v), .fe_det(fe_det),
    .rx_en(rx_en), .u2x(u2x), .chr_size(chr_size), .upm(upm), .rx_rd(rx_rd),
    .rx_data(rx_data), .rxc(rxc), .fe(fe), .pe(pe), .dor(dor), .busy(busy)
  );

  typedef struct {
    logic [8:0] d;
    logic [2:0] cs;
    logic       x2;
    logic [1:0] pm;
    logic       flip;
    logic       stp;
    logic [8:0] ed;
    logic       efe;
    logic       epe;
  } vec_t;

  vec_t vt[8];

  task automatic chk9(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  // One oversample tick followed by one quiet clock; the voter's fe_det is modelled here.
  task automatic tick(input logic lvl, input logic rd);
    rxd_v     = lvl;
    fe_det    = prev_lvl & ~lvl;
    samp_tick = 1'b1;
    rx_rd     = rd;
    @(posedge clk); #1;
    samp_tick = 1'b0;
    fe_det    = 1'b0;
    rx_rd     = 1'b0;
    prev_lvl  = lvl;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) tick(lvl, 1'b0);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    @(posedge clk); #1;
    rx_rd = 1'b0;
  endtask

  function automatic int nb_of(input logic [2:0] cs);
    case (cs)
      3'd0: return 5;
      3'd1: return 6;
      3'd2: return 7;
      3'd7: return 9;
      default: return 8;
    endcase
  endfunction

  task automatic send_frame(input logic [8:0] d, input logic flip, input logic stp, input logic rd_end);
    int os, half, nb;
    logic p;
    os   = u2x ? 8 : 16;
    half = os / 2;
    nb   = nb_of(chr_size);
    p    = upm[0] ^ flip;
    ticks(1'b1, 2);
    ticks(1'b0, os);
    for (int k = 0; k < nb; k++) begin
      ticks(d[k], os);
      p = p ^ d[k];
    end
    if (upm[1]) ticks(p, os);
    ticks(stp, half);
    tick(stp, rd_end);
    chk1("stop_busy", busy, 1'b0);
    chk1("stop_rxc", rxc, 1'b1);
    ticks(1'b1, os - half - 1);
  endtask

  initial begin
    rst = 1'b1; samp_tick = 1'b0; rxd_v = 1'b1; fe_det = 1'b0; rx_en = 1'b1;
    u2x = 1'b0; chr_size = 3'd3; upm = 2'b00; rx_rd = 1'b0;

    vt[0] = '{9'h0A5, 3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vt[1] = '{9'h1C3, 3'd7, 1'b1, 2'b10, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0};
    vt[2] = '{9'h1C3, 3'd7, 1'b1, 2'b10, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b1};
    vt[3] = '{9'h03C, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
    vt[4] = '{9'h015, 3'd0, 1'b1, 2'b11, 1'b0, 1'b1, 9'h015, 1'b0, 1'b0};
    vt[5] = '{9'h07F, 3'd1, 1'b0, 2'b00, 1'b0, 1'b1, 9'h03F, 1'b0, 1'b0};
    vt[6] = '{9'h055, 3'd2, 1'b1, 2'b11, 1'b1, 1'b1, 9'h055, 1'b0, 1'b1};
    vt[7] = '{9'h0C3, 3'd5, 1'b0, 2'b00, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk9("rst_data", rx_data, 9'h000);
    chk1("rst_rxc", rxc, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_dor", dor, 1'b0);

    for (int i = 0; i < 8; i++) begin
      u2x = vt[i].x2; chr_size = vt[i].cs; upm = vt[i].pm;
      send_frame(vt[i].d, vt[i].flip, vt[i].stp, 1'b0);
      chk9($sformatf("v%0d_data", i), rx_data, vt[i].ed);
      chk1($sformatf("v%0d_fe", i), fe, vt[i].efe);
      chk1($sformatf("v%0d_pe", i), pe, vt[i].epe);
      chk1($sformatf("v%0d_dor", i), dor, 1'b0);
      pop();
      chk1($sformatf("v%0d_pop_rxc", i), rxc, 1'b0);
      chk1($sformatf("v%0d_pop_flags", i), fe | pe, 1'b0);
    end

    // Glitch: low for 3 ticks, high through the start centre
    u2x = 1'b0; chr_size = 3'd3; upm = 2'b00;
    ticks(1'b1, 2);
    ticks(1'b0, 3);
    chk1("glitch_busy_mid", busy, 1'b1);
    ticks(1'b1, 6);
    chk1("glitch_busy_end", busy, 1'b0);
    ticks(1'b1, 20);
    chk1("glitch_rxc", rxc, 1'b0);

    // Overrun, then pop
    send_frame(9'h011, 1'b0, 1'b1, 1'b0);
    send_frame(9'h022, 1'b0, 1'b1, 1'b0);
    chk9("ovr_data", rx_data, 9'h011);
    chk1("ovr_dor", dor, 1'b1);
    pop();
    chk1("ovr_pop_rxc", rxc, 1'b0);
    chk1("ovr_pop_dor", dor, 1'b0);
    chk9("ovr_pop_hold", rx_data, 9'h011);

    // Pop in the completion cycle of the second frame
    send_frame(9'h011, 1'b0, 1'b1, 1'b0);
    send_frame(9'h022, 1'b0, 1'b1, 1'b1);
    chk9("rdc_data", rx_data, 9'h022);
    chk1("rdc_dor", dor, 1'b0);
    chk1("rdc_rxc", rxc, 1'b1);

    // Receiver disable mid-DATA flushes the buffer
    ticks(1'b1, 2);
    ticks(1'b0, 16);
    ticks(1'b1, 3);
    chk1("dis_busy_pre", busy, 1'b1);
    rx_en = 1'b0;
    @(posedge clk); #1;
    chk1("dis_busy", busy, 1'b0);
    chk1("dis_rxc", rxc, 1'b0);
    chk9("dis_data", rx_data, 9'h000);
    rx_en = 1'b1;

    // Reset mid-frame with a full buffer
    send_frame(9'h077, 1'b0, 1'b1, 1'b0);
    ticks(1'b1, 2);
    ticks(1'b0, 16);
    ticks(1'b0, 5);
    chk1("rst2_busy_pre", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("rst2_busy", busy, 1'b0);
    chk1("rst2_rxc", rxc, 1'b0);
    chk9("rst2_data", rx_data, 9'h000);

    send_frame(9'h05A, 1'b0, 1'b1, 1'b0);
    chk9("post_data", rx_data, 9'h05A);
    chk1("post_fe", fe, 1'b0);
    chk1("post_pe", pe, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
